// File: rtl/cpu_pkg.sv
// Definitions shared between the control unit and the datapath: widths, opcodes,
// datapath path selects and the instruction-fetch FSM state encoding.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W  = 8;
  localparam int unsigned CPU_INSTR_W = 24;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_JMP   = 8'h05;
  localparam logic [7:0] OP_MOVI  = 8'h06;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [1:0] {
    PATH_ALU,
    PATH_MEM,
    PATH_IMM,
    PATH_PC
  } path_t;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_FULL
  } fetch_state_t;

  function automatic logic [7:0] opcode_of(input logic [CPU_INSTR_W-1:0] instr);
    return instr[23:16];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_rise_detect.sv
// Registered rising-edge detector. The previous sample resets to 1 so a level
// held high through reset does not produce an event.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic fire
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign fire = level & ~prev;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-side datapath: PC, MAR and IR, plus the request/wait/buffer FSM that
// reads the instruction memory on behalf of the control unit.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = CPU_ADDR_W,
  parameter int unsigned INSTR_W = CPU_INSTR_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_load_val,
  input  logic               pc_en,
  input  logic               pc_inc,
  input  logic               mar_load,
  input  logic               ir_load,
  output logic [INSTR_W-1:0] command_word,
  output logic               ready_reg_flag,
  output logic [ADDR_W-1:0]  pc_current,
  output logic               fetch_timeout,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_req,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_rvalid
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t state, state_next;

  logic [ADDR_W-1:0]  pc, mar;
  logic [INSTR_W-1:0] ir, buffer;
  logic [CNT_W-1:0]   cnt;
  logic               flag;
  logic               pc_inc_ev, mar_load_ev;

  logic mar_en, flag_set, ir_from_mem, ir_from_buf, buf_en, cnt_clr, cnt_inc;

  rise_detect u_pc_inc_edge (
    .clk   (clk),
    .rst   (rst),
    .level (pc_inc),
    .fire  (pc_inc_ev)
  );

  rise_detect u_mar_load_edge (
    .clk   (clk),
    .rst   (rst),
    .level (mar_load),
    .fire  (mar_load_ev)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_IDLE;
    else     state <= state_next;
  end

  // Expiry is decided in the last WAIT cycle so a response arriving in that
  // same cycle still wins over the timeout.
  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    fetch_timeout = 1'b0;
    mar_en        = 1'b0;
    flag_set      = 1'b0;
    ir_from_mem   = 1'b0;
    ir_from_buf   = 1'b0;
    buf_en        = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (mar_load_ev) begin
          mar_en     = 1'b1;
          flag_set   = 1'b1;
          state_next = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        mem_req    = 1'b1;
        cnt_clr    = 1'b1;
        state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (mem_rvalid) begin
          if (ir_load) begin
            ir_from_mem = 1'b1;
            state_next  = FETCH_IDLE;
          end else begin
            buf_en     = 1'b1;
            state_next = FETCH_FULL;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          fetch_timeout = 1'b1;
          state_next    = FETCH_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FETCH_FULL: begin
        if (ir_load) begin
          ir_from_buf = 1'b1;
          state_next  = FETCH_IDLE;
        end
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      mar    <= '0;
      ir     <= '0;
      buffer <= '0;
      cnt    <= '0;
      flag   <= 1'b1;
    end else begin
      if (pc_en)          pc <= pc_load_val;
      else if (pc_inc_ev) pc <= pc + 1'b1;

      if (mar_en) mar <= pc;

      if (buf_en) buffer <= mem_rdata;

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;

      if (ir_from_mem) begin
        ir   <= mem_rdata;
        flag <= 1'b0;
      end else if (ir_from_buf) begin
        ir   <= buffer;
        flag <= 1'b0;
      end else if (flag_set) begin
        flag <= 1'b1;
      end
    end
  end

  assign command_word   = ir;
  assign ready_reg_flag = flag;
  assign pc_current     = pc;
  assign mem_addr       = mar;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table for the basic
// fetch and PC behaviour, then hand-written multi-cycle sequences.
module tb_instr_fetch_unit;

  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc_load_val;
  logic        pc_en, pc_inc, mar_load, ir_load;
  logic [23:0] command_word;
  logic        ready_reg_flag;
  logic [7:0]  pc_current;
  logic        fetch_timeout;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic [23:0] mem_rdata;
  logic        mem_rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W  (8),
    .INSTR_W (24),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_load_val    (pc_load_val),
    .pc_en          (pc_en),
    .pc_inc         (pc_inc),
    .mar_load       (mar_load),
    .ir_load        (ir_load),
    .command_word   (command_word),
    .ready_reg_flag (ready_reg_flag),
    .pc_current     (pc_current),
    .fetch_timeout  (fetch_timeout),
    .mem_addr       (mem_addr),
    .mem_req        (mem_req),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid)
  );

  typedef struct {
    logic        pc_en;
    logic [7:0]  pc_val;
    logic        pc_inc;
    logic        mar_load;
    logic        ir_load;
    logic        rvalid;
    logic [23:0] rdata;
    logic [23:0] e_cmd;
    logic        e_flag;
    logic [7:0]  e_pc;
    logic        e_req;
    logic [7:0]  e_addr;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic en, input logic [7:0] val, input logic inc,
                              input logic mar, input logic irl, input logic rv,
                              input logic [23:0] rd, input logic [23:0] cmd,
                              input logic flg, input logic [7:0] pc, input logic req,
                              input logic [7:0] addr);
    vec_t v;
    v.pc_en = en;  v.pc_val = val; v.pc_inc = inc; v.mar_load = mar;
    v.ir_load = irl; v.rvalid = rv; v.rdata = rd;
    v.e_cmd = cmd; v.e_flag = flg; v.e_pc = pc; v.e_req = req; v.e_addr = addr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " cmd"},  32'(command_word), 32'h0);
    chk({tag, " flag"}, 32'(ready_reg_flag), 32'h1);
    chk({tag, " pc"},   32'(pc_current), 32'h0);
    chk({tag, " req"},  32'(mem_req), 32'h0);
    chk({tag, " to"},   32'(fetch_timeout), 32'h0);
    chk({tag, " addr"}, 32'(mem_addr), 32'h0);
  endtask

  initial begin
    // Fetch from address 0 (rvalid two cycles after the request), then PC wrap and load priority.
    vecs[0]  = mk(0, 8'h00, 0, 0, 0, 0, 24'h0,      24'h0,      1, 8'h00, 0, 8'h00);
    vecs[1]  = mk(0, 8'h00, 0, 1, 1, 0, 24'h0,      24'h0,      1, 8'h00, 0, 8'h00);
    vecs[2]  = mk(0, 8'h00, 0, 1, 1, 0, 24'h0,      24'h0,      1, 8'h00, 1, 8'h00);
    vecs[3]  = mk(0, 8'h00, 0, 0, 1, 0, 24'h0,      24'h0,      1, 8'h00, 0, 8'h00);
    vecs[4]  = mk(0, 8'h00, 0, 0, 1, 0, 24'h0,      24'h0,      1, 8'h00, 0, 8'h00);
    vecs[5]  = mk(0, 8'h00, 0, 0, 1, 1, 24'h060102, 24'h0,      1, 8'h00, 0, 8'h00);
    vecs[6]  = mk(0, 8'h00, 0, 0, 0, 0, 24'h0,      24'h060102, 0, 8'h00, 0, 8'h00);
    vecs[7]  = mk(1, 8'hFF, 0, 0, 0, 0, 24'h0,      24'h060102, 0, 8'h00, 0, 8'h00);
    vecs[8]  = mk(0, 8'h00, 1, 0, 0, 0, 24'h0,      24'h060102, 0, 8'hFF, 0, 8'h00);
    vecs[9]  = mk(0, 8'h00, 1, 0, 0, 0, 24'h0,      24'h060102, 0, 8'h00, 0, 8'h00);
    vecs[10] = mk(0, 8'h00, 1, 0, 0, 0, 24'h0,      24'h060102, 0, 8'h00, 0, 8'h00);
    vecs[11] = mk(0, 8'h00, 1, 0, 0, 0, 24'h0,      24'h060102, 0, 8'h00, 0, 8'h00);
    vecs[12] = mk(0, 8'h00, 1, 0, 0, 0, 24'h0,      24'h060102, 0, 8'h00, 0, 8'h00);
    vecs[13] = mk(0, 8'h00, 0, 0, 0, 0, 24'h0,      24'h060102, 0, 8'h00, 0, 8'h00);
    vecs[14] = mk(1, 8'h20, 1, 0, 0, 0, 24'h0,      24'h060102, 0, 8'h00, 0, 8'h00);
    vecs[15] = mk(0, 8'h00, 0, 0, 0, 0, 24'h0,      24'h060102, 0, 8'h20, 0, 8'h00);
    vecs[16] = mk(0, 8'h00, 0, 0, 0, 0, 24'h0,      24'h060102, 0, 8'h20, 0, 8'h00);

    rst = 1'b1; pc_load_val = '0; pc_en = 0; pc_inc = 0; mar_load = 0; ir_load = 0;
    mem_rdata = '0; mem_rvalid = 0;
    tick();
    tick();
    chk_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      pc_en = vecs[i].pc_en; pc_load_val = vecs[i].pc_val; pc_inc = vecs[i].pc_inc;
      mar_load = vecs[i].mar_load; ir_load = vecs[i].ir_load;
      mem_rvalid = vecs[i].rvalid; mem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d cmd", i),  32'(command_word),   32'(vecs[i].e_cmd));
      chk($sformatf("vec%0d flag", i), 32'(ready_reg_flag), 32'(vecs[i].e_flag));
      chk($sformatf("vec%0d pc", i),   32'(pc_current),     32'(vecs[i].e_pc));
      chk($sformatf("vec%0d req", i),  32'(mem_req),        32'(vecs[i].e_req));
      chk($sformatf("vec%0d addr", i), 32'(mem_addr),       32'(vecs[i].e_addr));
      chk($sformatf("vec%0d to", i),   32'(fetch_timeout),  32'h0);
      tick();
    end
    pc_en = 0; pc_inc = 0; mar_load = 0; ir_load = 0; mem_rvalid = 0; mem_rdata = '0;

    // Timeout with no response; a mar_load edge inside WAIT must not re-request.
    mar_load = 1; #1; tick();
    mar_load = 0; #1;
    chk("to req", 32'(mem_req), 32'h1);
    chk("to addr", 32'(mem_addr), 32'h20);
    chk("to flag", 32'(ready_reg_flag), 32'h1);
    tick();
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      mar_load = (k == 3);
      #1;
      chk($sformatf("to wait%0d req", k), 32'(mem_req), 32'h0);
      chk($sformatf("to wait%0d pulse", k), 32'(fetch_timeout), 32'(k == int'(TIMEOUT)));
      tick();
    end
    mar_load = 0; #1;
    chk("to after pulse", 32'(fetch_timeout), 32'h0);
    chk("to after flag", 32'(ready_reg_flag), 32'h1);
    chk("to after cmd", 32'(command_word), 32'h060102);
    chk("to after req", 32'(mem_req), 32'h0);
    mem_rvalid = 1; mem_rdata = 24'hABCDEF; ir_load = 1; #1;
    tick();
    mem_rvalid = 0; ir_load = 0; #1;
    chk("late rvalid cmd", 32'(command_word), 32'h060102);
    chk("late rvalid flag", 32'(ready_reg_flag), 32'h1);

    // Response arriving in the expiry cycle is accepted and suppresses the timeout.
    mar_load = 1; #1; tick();
    mar_load = 0; #1;
    chk("exp req", 32'(mem_req), 32'h1);
    tick();
    for (int k = 1; k < int'(TIMEOUT); k++) tick();
    mem_rvalid = 1; mem_rdata = 24'h112233; ir_load = 1; #1;
    chk("exp pulse", 32'(fetch_timeout), 32'h0);
    tick();
    mem_rvalid = 0; ir_load = 0; #1;
    chk("exp cmd", 32'(command_word), 32'h112233);
    chk("exp flag", 32'(ready_reg_flag), 32'h0);

    // Buffered response, IR loaded three cycles later; mar_load in FULL ignored.
    pc_en = 1; pc_load_val = 8'h40; #1; tick();
    pc_en = 0;
    mar_load = 1; #1; tick();
    mar_load = 0; #1;
    chk("full req", 32'(mem_req), 32'h1);
    chk("full addr", 32'(mem_addr), 32'h40);
    tick();
    mem_rvalid = 1; mem_rdata = 24'h0A0B0C; ir_load = 0; #1;
    tick();
    mem_rvalid = 0; mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      mar_load = (i == 0);
      pc_inc   = (i == 0);
      #1;
      chk($sformatf("full%0d req", i), 32'(mem_req), 32'h0);
      chk($sformatf("full%0d flag", i), 32'(ready_reg_flag), 32'h1);
      chk($sformatf("full%0d cmd", i), 32'(command_word), 32'h112233);
      tick();
    end
    mar_load = 0; pc_inc = 0;
    ir_load = 1; #1;
    chk("full pre-load cmd", 32'(command_word), 32'h112233);
    tick();
    ir_load = 0; #1;
    chk("full load cmd", 32'(command_word), 32'h0A0B0C);
    chk("full load flag", 32'(ready_reg_flag), 32'h0);
    chk("full mar kept", 32'(mem_addr), 32'h40);
    chk("full pc inc", 32'(pc_current), 32'h41);
    chk("full no req", 32'(mem_req), 32'h0);

    // Reset in WAIT with a response the following cycle; mar_load held through reset.
    mar_load = 1; #1; tick();
    mar_load = 0; #1; tick();
    rst = 1; mar_load = 1; #1; tick();
    rst = 0; mem_rvalid = 1; mem_rdata = 24'h123456; ir_load = 1; #1;
    chk_reset_state("rst wait");
    tick();
    mem_rvalid = 0; ir_load = 0; #1;
    chk("rst discard cmd", 32'(command_word), 32'h0);
    chk("rst discard flag", 32'(ready_reg_flag), 32'h1);
    chk("rst held mar req", 32'(mem_req), 32'h0);
    tick();
    chk("rst held mar req2", 32'(mem_req), 32'h0);
    mar_load = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
